vc_control: RTL and testbench
=============================

VC_CONTROL -- requirements
Module: vc_control

Interface
REQ-001 Parameter IDX_W, default 3: victim-cache way index width (8 ways).
REQ-002 Parameter CNT_W, default 16: performance counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 l2_req  input  1  L2 miss lookup request; held high until l2_resp.
REQ-006 l2_evict  input  1  L2 victim-insert request; held high until evict_ack.
REQ-007 l2_evict_dirty  input  1  dirty status of the line L2 is evicting.
REQ-008 vc_hit  input  1  datapath: some valid way matches the presented L2 address.
REQ-009 hit_way  input  IDX_W  datapath: matching way number.
REQ-010 lru_way  input  IDX_W  datapath: replacement way, with invalid ways preferred.
REQ-011 lru_valid, lru_dirty  input  1 each  valid/dirty bits of lru_way.
REQ-012 mem_resp  input  1  memory write-back complete, one-cycle pulse.
REQ-013 l2_resp, l2_hit  output  1 each  lookup done (pulse); hit qualifier.
REQ-014 evict_ack  output  1  victim insert done, one-cycle pulse.
REQ-015 load_vc, load_lru  output  1 each  datapath array/LRU write enables.
REQ-016 vc_index  output  IDX_W  way selected for read/write.
REQ-017 vc_valid_bit, vc_dirty_bit  output  1 each  bits written with load_vc.
REQ-018 mem_write  output  1  write-back of way vc_index to memory, level.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 hit_count, miss_count  output  CNT_W each  lookup statistics.

Function
REQ-021 FSM states: IDLE, LOOKUP, EVICT_CHK, WRITEBACK, INSERT; all outputs Moore/state-decoded, default 0.
REQ-022 IDLE: l2_req -> LOOKUP; else l2_evict -> EVICT_CHK; l2_req wins when both high, evict served on the next IDLE visit.
REQ-023 LOOKUP (one cycle, l2_resp=1): vc_hit -> l2_hit=1, vc_index=hit_way, load_vc=1, vc_valid_bit=0 (line migrates to L2), load_lru=1; miss -> l2_hit=0, no writes; always -> IDLE.
REQ-024 Lookup latency: l2_resp high exactly one cycle after the edge on which IDLE samples l2_req.
REQ-025 EVICT_CHK (one cycle): lru_valid && lru_dirty -> WRITEBACK; else -> INSERT.
REQ-026 WRITEBACK: mem_write=1, vc_index=lru_way held stable; stay until mem_resp, then -> INSERT.
REQ-027 INSERT (one cycle): vc_index=lru_way, load_vc=1, vc_valid_bit=1, vc_dirty_bit=l2_evict_dirty, load_lru=1, evict_ack=1 -> IDLE.
REQ-028 Clean or invalid LRU victim: evict_ack two cycles after IDLE samples l2_evict.
REQ-029 mem_resp outside WRITEBACK ignored; vc_hit/hit_way ignored outside LOOKUP.
REQ-030 Request drop mid-transaction does not abort; the current transaction completes.
REQ-031 load_vc and mem_write never asserted in the same cycle.

Reset
REQ-032 rst_n low: FSM -> IDLE immediately; all outputs 0, including mid-WRITEBACK mem_write; counters 0.
REQ-033 First transaction is accepted on the first rising edge with rst_n high.

Configuration
REQ-034 Macro VC_PERF_CNT_EN defined: hit_count/miss_count increment in LOOKUP on hit/miss, saturating at all-ones, no wrap.
REQ-035 VC_PERF_CNT_EN undefined: counter registers absent, hit_count/miss_count tied to 0, all other behaviour identical.

Verification
REQ-036 After reset, l2_req=1 with vc_hit=1, hit_way=5 -> next cycle l2_resp=1, l2_hit=1, vc_index=5, load_vc=1, vc_valid_bit=0, load_lru=1.
REQ-037 l2_evict=1, l2_evict_dirty=1, lru_way=2, lru_valid=0 -> INSERT in cycle 2: vc_index=2, vc_valid_bit=1, vc_dirty_bit=1, evict_ack=1; mem_write never high.
REQ-038 l2_evict with lru_valid=1, lru_dirty=1, lru_way=7; mem_resp 4 cycles later -> mem_write high 4 cycles at vc_index=7, INSERT on the cycle after mem_resp.
REQ-039 l2_req and l2_evict high together in IDLE -> LOOKUP serviced first, l2_resp, then EVICT_CHK on next IDLE, evict_ack.
REQ-040 rst_n low during WRITEBACK -> mem_write and busy 0 immediately; no evict_ack; with macro, 0xFFFF hits plus one more lookup hit -> hit_count stays 0xFFFF.

Source files
------------

// File: rtl/vc_control.sv
// vc_control: victim-cache controller FSM for L2 miss lookups and L2 victim inserts with write-back.
// Define VC_PERF_CNT_EN to build the saturating hit/miss counters; otherwise they read as zero.
module vc_control #(
  parameter int IDX_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_l2_req,
  input  logic             i_l2_evict,
  input  logic             i_l2_evict_dirty,
  input  logic             i_vc_hit,
  input  logic [IDX_W-1:0] i_hit_way,
  input  logic [IDX_W-1:0] i_lru_way,
  input  logic             i_lru_valid,
  input  logic             i_lru_dirty,
  input  logic             i_mem_resp,
  output logic             o_l2_resp,
  output logic             o_l2_hit,
  output logic             o_evict_ack,
  output logic             o_load_vc,
  output logic             o_load_lru,
  output logic [IDX_W-1:0] o_vc_index,
  output logic             o_vc_valid_bit,
  output logic             o_vc_dirty_bit,
  output logic             o_mem_write,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_hit_count,
  output logic [CNT_W-1:0] o_miss_count
);
  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT_CHK, WRITEBACK, INSERT} state_t;
  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_victim;
  logic             w_lk_hit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // victim way is frozen at the check so write-back and insert target the same way
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                    r_victim <= '0;
    else if (r_state == EVICT_CHK) r_victim <= i_lru_way;
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:      w_next = i_l2_req ? LOOKUP : i_l2_evict ? EVICT_CHK : IDLE;
      EVICT_CHK: w_next = (i_lru_valid && i_lru_dirty) ? WRITEBACK : INSERT;
      WRITEBACK: w_next = i_mem_resp ? INSERT : WRITEBACK;
      default:   w_next = IDLE;
    endcase
  end
  always_comb begin
    w_lk_hit       = (r_state == LOOKUP) && i_vc_hit;
    o_l2_resp      = r_state == LOOKUP;
    o_l2_hit       = w_lk_hit;
    o_evict_ack    = r_state == INSERT;
    o_load_vc      = w_lk_hit || (r_state == INSERT);
    o_load_lru     = w_lk_hit || (r_state == INSERT);
    o_vc_index     = w_lk_hit ? i_hit_way :
                     (r_state == WRITEBACK || r_state == INSERT) ? r_victim : '0;
    o_vc_valid_bit = r_state == INSERT;
    o_vc_dirty_bit = (r_state == INSERT) && i_l2_evict_dirty;
    o_mem_write    = r_state == WRITEBACK;
    o_busy         = r_state != IDLE;
  end
`ifdef VC_PERF_CNT_EN
  logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == LOOKUP) begin
      if (i_vc_hit && !(&r_hit_cnt))   r_hit_cnt  <= r_hit_cnt + 1'b1;
      if (!i_vc_hit && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  assign o_hit_count  = r_hit_cnt;
  assign o_miss_count = r_miss_cnt;
`else
  assign o_hit_count  = '0;
  assign o_miss_count = '0;
`endif
endmodule

// File: tb/tb_vc_control.sv
// tb_vc_control: directed transactions against a per-cycle expectation timeline built from transaction parameters.
module tb_vc_control;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
`ifdef VC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_l2_req = 0, i_l2_evict = 0, i_l2_evict_dirty = 0, i_vc_hit = 0;
  logic [2:0] i_hit_way = 0, i_lru_way = 0;
  logic i_lru_valid = 0, i_lru_dirty = 0, i_mem_resp = 0;
  logic o_l2_resp, o_l2_hit, o_evict_ack, o_load_vc, o_load_lru;
  logic [2:0] o_vc_index;
  logic o_vc_valid_bit, o_vc_dirty_bit, o_mem_write, o_busy;
  logic [CW-1:0] o_hit_count, o_miss_count;

  vc_control #(.IDX_W(3), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i_l2_req(i_l2_req), .i_l2_evict(i_l2_evict),
    .i_l2_evict_dirty(i_l2_evict_dirty), .i_vc_hit(i_vc_hit), .i_hit_way(i_hit_way),
    .i_lru_way(i_lru_way), .i_lru_valid(i_lru_valid), .i_lru_dirty(i_lru_dirty),
    .i_mem_resp(i_mem_resp), .o_l2_resp(o_l2_resp), .o_l2_hit(o_l2_hit),
    .o_evict_ack(o_evict_ack), .o_load_vc(o_load_vc), .o_load_lru(o_load_lru),
    .o_vc_index(o_vc_index), .o_vc_valid_bit(o_vc_valid_bit), .o_vc_dirty_bit(o_vc_dirty_bit),
    .o_mem_write(o_mem_write), .o_busy(o_busy), .o_hit_count(o_hit_count),
    .o_miss_count(o_miss_count));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc_n = 0, mw_cnt = 0, ack_cnt = 0, ack_cyc = 0, ack_idx = 0, ack_vb = 0, ack_db = 0;
  int m_hit = 0, m_miss = 0;
  bit chk_en = 0;
  logic e_resp, e_hit, e_ack, e_lvc, e_llru, e_vb, e_db, e_mw, e_bsy;
  logic [2:0] e_idx;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (o_mem_write === 1'b1) mw_cnt++;
    if (o_evict_ack === 1'b1) begin
      ack_cnt++; ack_cyc = cyc_n; ack_idx = int'(o_vc_index);
      ack_vb = int'(o_vc_valid_bit); ack_db = int'(o_vc_dirty_bit);
    end
    if (chk_en) begin
      logic [CW-1:0] eh, em;
      eh = PERF ? CW'(m_hit) : '0;
      em = PERF ? CW'(m_miss) : '0;
      checks++;
      if ({o_l2_resp, o_l2_hit, o_evict_ack, o_load_vc, o_load_lru, o_vc_index, o_vc_valid_bit,
           o_vc_dirty_bit, o_mem_write, o_busy, o_hit_count, o_miss_count} !==
          {e_resp, e_hit, e_ack, e_lvc, e_llru, e_idx, e_vb, e_db, e_mw, e_bsy, eh, em}) begin
        errors++;
        $display("FAIL cycle%0d outputs: got resp=%b hit=%b ack=%b lvc=%b llru=%b idx=%0d vb=%b db=%b mw=%b busy=%b hc=%0d mc=%0d expected resp=%b hit=%b ack=%b lvc=%b llru=%b idx=%0d vb=%b db=%b mw=%b busy=%b hc=%0d mc=%0d",
                 cyc_n, o_l2_resp, o_l2_hit, o_evict_ack, o_load_vc, o_load_lru, o_vc_index,
                 o_vc_valid_bit, o_vc_dirty_bit, o_mem_write, o_busy, o_hit_count, o_miss_count,
                 e_resp, e_hit, e_ack, e_lvc, e_llru, e_idx, e_vb, e_db, e_mw, e_bsy, eh, em);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_exp(input logic resp, hit, ack, lvc, llru, input logic [2:0] idx,
                         input logic vb, db, mw, bsy);
    e_resp = resp; e_hit = hit; e_ack = ack; e_lvc = lvc; e_llru = llru;
    e_idx = idx; e_vb = vb; e_db = db; e_mw = mw; e_bsy = bsy;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cyc(input logic resp, hit, ack, lvc, llru, input logic [2:0] idx,
                     input logic vb, db, mw, bsy);
    set_exp(resp, hit, ack, lvc, llru, idx, vb, db, mw, bsy);
    step();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
  endtask

  task automatic count(input logic hit);
    if (hit) m_hit = (m_hit < MAXC) ? m_hit + 1 : m_hit;
    else     m_miss = (m_miss < MAXC) ? m_miss + 1 : m_miss;
  endtask

  task automatic lookup(input logic hit, input logic [2:0] way);
    i_l2_req = 1;
    idle();
    i_vc_hit = hit; i_hit_way = way;
    cyc(1, hit, 0, hit, hit, hit ? way : 3'd0, 0, 0, 0, 1);
    count(hit);
    i_l2_req = 0; i_vc_hit = 0;
  endtask

  // n = write-back cycles before memory completes; drop releases l2_evict mid write-back
  task automatic evict(input logic dty, input logic [2:0] way, input logic v, d,
                       input int n, input logic drop);
    i_l2_evict = 1; i_l2_evict_dirty = dty; i_lru_way = way; i_lru_valid = v; i_lru_dirty = d;
    idle();
    i_mem_resp = 1;
    cyc(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1);
    i_mem_resp = 0;
    if (v && d)
      for (int i = 0; i < n; i++) begin
        if (drop) i_l2_evict = 0;
        i_mem_resp = (i == n - 1);
        cyc(0, 0, 0, 0, 0, way, 0, 0, 1, 1);
      end
    i_mem_resp = 0;
    cyc(0, 0, 1, 1, 1, way, 1, dty, 0, 1);
    i_l2_evict = 0; i_lru_valid = 0; i_lru_dirty = 0;
  endtask

  initial begin
    int t0, m0, a0;
    step(); step(); #1;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_resp", int'(o_l2_resp), 0);
    chk("rst_mw", int'(o_mem_write), 0);
    chk("rst_hc", int'(o_hit_count), 0);
    @(posedge clk); #1;
    rst_n = 1; chk_en = 1;
    i_l2_req = 1;
    idle();
    i_vc_hit = 1; i_hit_way = 3'd5;
    set_exp(1, 1, 0, 1, 1, 3'd5, 0, 0, 0, 1);
    @(negedge clk);
    chk("first_resp", int'(o_l2_resp), 1);
    chk("first_hit", int'(o_l2_hit), 1);
    chk("first_idx", int'(o_vc_index), 5);
    chk("first_lvc", int'(o_load_vc), 1);
    chk("first_vb", int'(o_vc_valid_bit), 0);
    chk("first_llru", int'(o_load_lru), 1);
    step();
    count(1);
    i_l2_req = 0; i_vc_hit = 0;
    lookup(0, 3'd3);
    lookup(1, 3'd0);
    lookup(1, 3'd7);
    i_mem_resp = 1; i_vc_hit = 1; i_hit_way = 3'd6;
    idle();
    i_mem_resp = 0; i_vc_hit = 0;
    idle();
    t0 = cyc_n; m0 = mw_cnt; a0 = ack_cnt;
    evict(1, 3'd2, 0, 0, 0, 0);
    chk("clean_ack_lat", ack_cyc - t0, 2);
    chk("clean_ack_idx", ack_idx, 2);
    chk("clean_ack_vb", ack_vb, 1);
    chk("clean_ack_db", ack_db, 1);
    chk("clean_no_mw", mw_cnt - m0, 0);
    chk("clean_acks", ack_cnt - a0, 1);
    evict(0, 3'd4, 1, 0, 0, 0);
    t0 = cyc_n; m0 = mw_cnt;
    evict(0, 3'd7, 1, 1, 4, 0);
    chk("wb_len", mw_cnt - m0, 4);
    chk("wb_ack_lat", ack_cyc - t0, 6);
    chk("wb_ack_idx", ack_idx, 7);
    idle();
    evict(1, 3'd1, 1, 1, 2, 1);
    idle();
    t0 = cyc_n; a0 = ack_cnt;
    i_l2_req = 1; i_l2_evict = 1; i_l2_evict_dirty = 0; i_lru_way = 3'd6; i_lru_valid = 0;
    idle();
    i_vc_hit = 1; i_hit_way = 3'd2;
    cyc(1, 1, 0, 1, 1, 3'd2, 0, 0, 0, 1);
    count(1);
    i_l2_req = 0; i_vc_hit = 0;
    idle();
    cyc(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1);
    cyc(0, 0, 1, 1, 1, 3'd6, 1, 0, 0, 1);
    i_l2_evict = 0;
    chk("both_ack_lat", ack_cyc - t0, 4);
    chk("both_acks", ack_cnt - a0, 1);
    a0 = ack_cnt;
    i_l2_evict = 1; i_l2_evict_dirty = 1; i_lru_way = 3'd3; i_lru_valid = 1; i_lru_dirty = 1;
    idle();
    cyc(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 3'd3, 0, 0, 1, 1);
    set_exp(0, 0, 0, 0, 0, 3'd3, 0, 0, 1, 1);
    #2;
    chk_en = 0; rst_n = 0;
    #1;
    chk("rstwb_mw", int'(o_mem_write), 0);
    chk("rstwb_busy", int'(o_busy), 0);
    chk("rstwb_ack", int'(o_evict_ack), 0);
    chk("rstwb_hc", int'(o_hit_count), 0);
    m_hit = 0; m_miss = 0;
    i_l2_evict = 0; i_lru_valid = 0; i_lru_dirty = 0;
    step();
    rst_n = 1; chk_en = 1;
    idle(); idle(); idle();
    chk("rstwb_no_ack", ack_cnt - a0, 0);
    for (int i = 0; i < MAXC; i++) lookup(1, 3'(i));
    #1;
    chk("sat_full", int'(o_hit_count), PERF ? 15 : 0);
    lookup(1, 3'd1);
    #1;
    chk("sat_hold", int'(o_hit_count), PERF ? 15 : 0);
    lookup(0, 3'd0);
    #1;
    chk("miss_one", int'(o_miss_count), PERF ? 1 : 0);
    idle(); idle();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
